// File: rtl/blocking_seq_pkg.sv
// Shared types and constants for the a/b/c/d update-chain sequencer.
// Holds the FSM state encoding, the operation order and the datapath constants.
package blocking_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Operation order within one iteration: a=b+c, d=a-3, b=d+10, c=c+1
  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_D = 2'd1;
  localparam logic [1:0] OP_B = 2'd2;
  localparam logic [1:0] OP_C = 2'd3;

  localparam int D_SUB = 32'sd3;
  localparam int B_ADD = 32'sd10;
  localparam int C_INC = 32'sd1;

endpackage

// File: rtl/seq_step_timer.sv
// Down-counter pacing the sequencer between operations.
// Load takes priority over enable; zero flag reflects the registered count.
module seq_step_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] cnt,
  output logic          zero
);

  logic [TW-1:0] cnt_r;

  // Count register: reload, decrement or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {TW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      cnt_r <= cnt_r - TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {TW{1'b0}});

endmodule

// File: rtl/blocking_seq_ctrl.sv
// Controller and register datapath for the chain a=b+c, d=a-3, b=d+10, c=c+1,
// one operation per STEP_CYC cycles, ITER iterations per run.
module blocking_seq_ctrl
  import blocking_seq_pkg::*;
#(
  parameter  int W        = 32,
  parameter  int STEP_CYC = 5,
  parameter  int ITER     = 4,
  localparam int CNTW     = $clog2(ITER + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic signed [W-1:0] init_a,
  input  logic signed [W-1:0] init_b,
  input  logic signed [W-1:0] init_c,
  input  logic signed [W-1:0] init_d,
  output logic signed [W-1:0] a,
  output logic signed [W-1:0] b,
  output logic signed [W-1:0] c,
  output logic signed [W-1:0] d,
  output logic                busy,
  output logic                done,
  output logic [1:0]          op_idx,
  output logic [CNTW-1:0]     iter_cnt
);

  localparam int            TW        = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [TW-1:0] TMR_LOAD  = TW'(STEP_CYC - 1);
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(ITER - 1);

  state_t                state_r, state_nxt_s, phase_s;
  logic signed [W-1:0]   a_r, b_r, c_r, d_r;
  logic signed [W-1:0]   a_nxt_s, b_nxt_s, c_nxt_s, d_nxt_s;
  logic                  busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic [1:0]            op_idx_r, op_nxt_s;
  logic [CNTW-1:0]       iter_cnt_r, iter_nxt_s;
  logic                  tmr_load_s, tmr_en_s, tmr_zero_s;
  logic [TW-1:0]         tmr_cnt_s;

  seq_step_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (TMR_LOAD),
    .en       (tmr_en_s),
    .cnt      (tmr_cnt_s),
    .zero     (tmr_zero_s)
  );

  // The execute cycle is the final wait cycle, so each op lands exactly STEP_CYC edges apart
  assign phase_s = ((state_r == WAIT) && tmr_zero_s) ? EXEC : state_r;

  // Next-state, datapath and timer control
  always_comb begin
    state_nxt_s = state_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    op_nxt_s    = op_idx_r;
    iter_nxt_s  = iter_cnt_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    c_nxt_s     = c_r;
    d_nxt_s     = d_r;
    tmr_load_s  = 1'b0;
    tmr_en_s    = 1'b0;
    case (phase_s)
      IDLE: begin
        if (start && !abort) begin
          a_nxt_s     = init_a;
          b_nxt_s     = init_b;
          c_nxt_s     = init_c;
          d_nxt_s     = init_d;
          op_nxt_s    = OP_A;
          iter_nxt_s  = {CNTW{1'b0}};
          busy_nxt_s  = 1'b1;
          tmr_load_s  = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (abort) begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          tmr_en_s    = 1'b1;
          state_nxt_s = WAIT;
        end
      end
      EXEC: begin
        if (abort) begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          case (op_idx_r)
            OP_A:    a_nxt_s = b_r + c_r;
            OP_D:    d_nxt_s = a_r - W'(D_SUB);
            OP_B:    b_nxt_s = d_r + W'(B_ADD);
            OP_C:    c_nxt_s = c_r + W'(C_INC);
            default: a_nxt_s = a_r;
          endcase
          op_nxt_s = op_idx_r + 2'd1;
          if (op_idx_r == OP_C) begin
            iter_nxt_s = iter_cnt_r + CNTW'(1);
          end else begin
            iter_nxt_s = iter_cnt_r;
          end
          if ((op_idx_r == OP_C) && (iter_cnt_r == LAST_ITER)) begin
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
            state_nxt_s = FIN;
          end else begin
            tmr_load_s  = 1'b1;
            state_nxt_s = WAIT;
          end
        end
      end
      FIN: begin
        state_nxt_s = IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      op_idx_r   <= 2'd0;
      iter_cnt_r <= {CNTW{1'b0}};
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      c_r        <= {W{1'b0}};
      d_r        <= {W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      op_idx_r   <= op_nxt_s;
      iter_cnt_r <= iter_nxt_s;
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      c_r        <= c_nxt_s;
      d_r        <= d_nxt_s;
    end
  end

  assign a        = a_r;
  assign b        = b_r;
  assign c        = c_r;
  assign d        = d_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign op_idx   = op_idx_r;
  assign iter_cnt = iter_cnt_r;

endmodule
